// File: rtl/duty_cycle_pkg.sv
// duty_cycle_pkg: shared state encoding and width helper for the duty-cycle meter
package duty_cycle_pkg;
  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/duty_cycle_channel.sv
// duty_cycle_channel: per-channel high-time counter (clk, rst_n, clr_i, inc_en_i, sig_i -> count_o)
module duty_cycle_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_en_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = clr_i ? '0 : count_q + CNT_W'(inc_en_i & sig_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/duty_cycle_meter.sv
// duty_cycle_meter: multi-channel windowed duty-cycle meter (clk, rst_n, enable, start, cont, sig_in -> duty_out, valid, busy, overrun); DUTY_CYCLE_SYNC_EN adds 2-flop input synchronisers
module duty_cycle_meter
  import duty_cycle_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WINDOW = 255,
  localparam int CNT_W = clog2(WINDOW + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      cont,
  input  logic [CHANNELS-1:0]       sig_in,
  output logic [CHANNELS*CNT_W-1:0] duty_out,
  output logic                      valid,
  output logic                      busy,
  output logic                      overrun
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CHANNELS*CNT_W-1:0] duty_q, duty_d, cnt;
  logic valid_q, overrun_q, overrun_d;
  logic measure, win_end, clr;
  logic [CHANNELS-1:0] sig_s;
`ifdef DUTY_CYCLE_SYNC_EN
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  assign sig_s = sync2_q;
`else
  assign sig_s = sig_in;
`endif
  // Counters are held clear while idle, so entering MEASURE always starts from zero.
  always_comb begin
    measure = state_q == MEASURE;
    win_end = measure && enable && win_q == CNT_W'(WINDOW - 1);
    clr = !measure || win_end;
    state_d = measure ? ((win_end && !cont) ? IDLE : MEASURE) : ((start || cont) ? MEASURE : IDLE);
    win_d = clr ? '0 : win_q + CNT_W'(enable);
    overrun_d = overrun_q | (start & measure);
    duty_d = duty_q;
    // The final sample is still in flight in the channel counters, so fold it in here.
    for (int c = 0; c < CHANNELS; c++)
      if (win_end) duty_d[c*CNT_W +: CNT_W] = cnt[c*CNT_W +: CNT_W] + CNT_W'(sig_s[c]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      win_q <= '0;
      duty_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      duty_q <= duty_d;
      valid_q <= win_end;
      overrun_q <= overrun_d;
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    duty_cycle_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .clr_i(clr),
      .inc_en_i(measure & enable),
      .sig_i(sig_s[i]),
      .count_o(cnt[i*CNT_W +: CNT_W])
    );
  end
  assign duty_out = duty_q;
  assign valid = valid_q;
  assign busy = measure;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_duty_cycle_meter.sv
// tb_duty_cycle_meter: directed checks of duty_cycle_meter at WINDOW=8 and WINDOW=255
module tb_duty_cycle_meter;
  logic clk = 0, rst_n = 0;
  logic enable = 0, start = 0, cont = 0;
  logic [3:0] sig_in = 0;
  logic [15:0] duty_out;
  logic valid, busy, overrun;
  logic en2 = 0, st2 = 0;
  logic [3:0] sig2 = 0;
  logic [31:0] duty2;
  logic valid2, busy2, overrun2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  duty_cycle_meter #(.CHANNELS(4), .WINDOW(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .cont(cont), .sig_in(sig_in),
    .duty_out(duty_out), .valid(valid), .busy(busy), .overrun(overrun));

  duty_cycle_meter #(.CHANNELS(4), .WINDOW(255)) dut_big (
    .clk(clk), .rst_n(rst_n), .enable(en2), .start(st2), .cont(1'b0), .sig_in(sig2),
    .duty_out(duty2), .valid(valid2), .busy(busy2), .overrun(overrun2));

  task tick(input logic e, input logic [3:0] s);
    enable = e;
    sig_in = s;
    @(posedge clk);
    #1;
  endtask

  task go();
    start = 1;
    tick(0, 4'h0);
    start = 0;
  endtask

  task test_reset();
    #1;
    checks++;
    if (duty_out !== 16'h0 || valid !== 0 || busy !== 0 || overrun !== 0) begin
      errors++;
      $display("FAIL reset: duty=%0h valid=%0b busy=%0b overrun=%0b, required 0 0 0 0", duty_out, valid, busy, overrun);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task test_single_shot();
    go();
    checks++;
    if (busy !== 1) begin errors++; $display("FAIL single_busy: got %0b required 1", busy); end
    for (int i = 0; i < 8; i++) begin
      tick(1, 4'b0101);
      checks++;
      if (valid !== (i == 7) || busy !== (i != 7)) begin
        errors++;
        $display("FAIL single_tick%0d: valid=%0b busy=%0b required %0b %0b", i, valid, busy, i == 7, i != 7);
      end
    end
    checks++;
    if (duty_out !== 16'h0808) begin errors++; $display("FAIL single_duty: got %0h required 0808", duty_out); end
    tick(0, 4'h0);
    checks++;
    if (valid !== 0 || duty_out !== 16'h0808) begin
      errors++;
      $display("FAIL single_hold: valid=%0b duty=%0h required 0 0808", valid, duty_out);
    end
  endtask

  task test_half_duty();
    go();
    for (int i = 0; i < 8; i++) tick(1, (i % 2 == 1) ? 4'b0010 : 4'b0000);
    checks++;
    if (valid !== 1 || duty_out !== 16'h0040) begin
      errors++;
      $display("FAIL half_duty: valid=%0b duty=%0h required 1 0040", valid, duty_out);
    end
  endtask

  task test_gated_enable();
    go();
    for (int i = 0; i < 16; i++) begin
      tick(i % 2 == 1, 4'b0001);
      if (i >= 14) begin
        checks++;
        if (valid !== (i == 15)) begin errors++; $display("FAIL gated_valid%0d: got %0b required %0b", i, valid, i == 15); end
      end
    end
    checks++;
    if (duty_out !== 16'h0008) begin errors++; $display("FAIL gated_duty: got %0h required 0008", duty_out); end
    go();
    for (int i = 0; i < 16; i++) tick(i % 2 == 1, (i % 2 == 1) ? 4'b0000 : 4'b0001);
    checks++;
    if (valid !== 1 || duty_out !== 16'h0000) begin
      errors++;
      $display("FAIL gated_offphase: valid=%0b duty=%0h required 1 0000", valid, duty_out);
    end
  endtask

  task test_continuous();
    int n;
    cont = 1;
    tick(0, 4'h0);
    for (int t = 0; t < 24; t++) begin
      n = (t < 8) ? 3 : (t < 16) ? 5 : 8;
      if (t == 18) cont = 0;
      tick(1, (t % 8 < n) ? 4'b0100 : 4'b0000);
      checks++;
      if (valid !== (t % 8 == 7)) begin errors++; $display("FAIL cont_valid%0d: got %0b required %0b", t, valid, t % 8 == 7); end
      if (t % 8 == 7) begin
        checks++;
        if (duty_out !== (16'(n) << 8) || busy !== (t < 16)) begin
          errors++;
          $display("FAIL cont_win%0d: duty=%0h busy=%0b required %0h %0b", t / 8, duty_out, busy, 16'(n) << 8, t < 16);
        end
      end
    end
    tick(0, 4'h0);
    checks++;
    if (busy !== 0 || valid !== 0) begin errors++; $display("FAIL cont_idle: busy=%0b valid=%0b required 0 0", busy, valid); end
  endtask

  task test_overrun();
    checks++;
    if (overrun !== 0) begin errors++; $display("FAIL overrun_pre: got %0b required 0", overrun); end
    go();
    for (int i = 0; i < 8; i++) begin
      start = (i == 2);
      tick(1, 4'hF);
      start = 0;
      checks++;
      if (valid !== (i == 7)) begin errors++; $display("FAIL overrun_valid%0d: got %0b required %0b", i, valid, i == 7); end
    end
    checks++;
    if (overrun !== 1 || duty_out !== 16'h8888) begin
      errors++;
      $display("FAIL overrun_set: overrun=%0b duty=%0h required 1 8888", overrun, duty_out);
    end
  endtask

  task test_reset_mid_window();
    go();
    for (int i = 0; i < 4; i++) tick(1, 4'hF);
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (duty_out !== 16'h0 || valid !== 0 || busy !== 0 || overrun !== 0) begin
      errors++;
      $display("FAIL midreset: duty=%0h valid=%0b busy=%0b overrun=%0b required 0 0 0 0", duty_out, valid, busy, overrun);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1, 4'hF);
      checks++;
      if (valid !== 0 || busy !== 0) begin errors++; $display("FAIL midreset_after%0d: valid=%0b busy=%0b required 0 0", i, valid, busy); end
    end
  endtask

  task test_window_255();
    int n;
    n = 0;
    st2 = 1;
    en2 = 1;
    sig2 = 4'hF;
    @(posedge clk);
    #1;
    st2 = 0;
    while (n < 300 && valid2 !== 1) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 255) begin errors++; $display("FAIL big_latency: got %0d cycles required 255", n); end
    checks++;
    if (duty2 !== 32'hFFFF_FFFF || busy2 !== 0 || overrun2 !== 0) begin
      errors++;
      $display("FAIL big_duty: duty=%0h busy=%0b overrun=%0b required ffffffff 0 0", duty2, busy2, overrun2);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_half_duty();
    test_gated_enable();
    test_continuous();
    test_overrun();
    test_reset_mid_window();
    test_window_255();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/duty_cycle_meter.md
Name: duty_cycle_meter

Overview:
- Multi-channel duty-cycle measurement block; the parametrised successor to the single-channel window/high-time counter pair.
- For each channel, counts the enabled clock cycles in which that channel's input is high over a programmable window of WINDOW enabled cycles, then latches the results with a valid pulse.
- Supports single-shot and continuous (back-to-back window) modes.
- Sits between the ring-oscillator/sense inputs and the display/readout logic.

Parameters:
- CHANNELS, 4, number of independent input channels (1..16).
- WINDOW, 255, enabled cycles per measurement window (2..65535).
- CNT_W, $clog2(WINDOW+1), width of each high-count result; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  window advance qualifier; cycles with enable=0 are not counted on any counter.
- start  input  1  single-cycle request to begin one window (single-shot mode).
- cont  input  1  1 = continuous mode, 0 = single-shot.
- sig_in  input  CHANNELS  per-channel measured signals.
- duty_out  output  CHANNELS*CNT_W  latched high counts; channel i occupies bits [i*CNT_W +: CNT_W].
- valid  output  1  one-cycle pulse when duty_out updates.
- busy  output  1  high while in MEASURE.
- overrun  output  1  sticky flag: start asserted while busy; cleared only by reset.

Behaviour:
- Reset (asynchronous, rst_n=0), all registered outputs and state:
  - duty_out=0, valid=0, busy=0, overrun=0, state=IDLE.
  - Window counter and all channel counters = 0.
- States:
  - IDLE:
    - If start=1 or cont=1, go to MEASURE next cycle.
    - The window counter and all channel counters are cleared on that transition.
  - MEASURE:
    - On each cycle with enable=1, win_cnt increments.
    - Channel i counter increments iff the sampled sig_in[i]=1.
    - Cycles with enable=0 hold all counters; the window pauses and does not time out.
    - On the enabled cycle where win_cnt==WINDOW-1 (the WINDOW-th enabled sample):
      - duty_out is loaded with each channel count including that cycle's sample.
      - valid=1 on the following cycle for exactly one cycle.
      - If cont=1 at that cycle, stay in MEASURE with all counters restarting from 0; the next cycle is sample 1 of the new window, with no gap.
      - Otherwise go to IDLE.
- busy=1 exactly when state==MEASURE (registered).
- Result range 0..WINDOW; no saturation logic is needed because a count cannot exceed WINDOW.
- start while busy is ignored for measurement and sets overrun.
- start and cont both 1 in IDLE is a single entry into MEASURE; the mode is sampled only at window end.
- cont deasserted mid-window: the current window completes, then the block goes to IDLE.
- duty_out holds its last value between windows; it is never cleared except by reset.
- Reset mid-window: the window is abandoned, duty_out=0, and no valid pulse is generated.

Optional Feature:
- Macro: DUTY_CYCLE_SYNC_EN.
- Defined:
  - Each sig_in bit passes through a 2-flop synchroniser (reset to 0) before counting.
  - Sampling latency is +2 cycles relative to sig_in; window boundaries are unchanged.
- Undefined:
  - sig_in is sampled directly; the inputs must already be synchronous to clk.

Decomposition:
- Package duty_cycle_pkg contains:
  - State encoding constants: IDLE=1'b0, MEASURE=1'b1.
  - A clog2 helper function used for CNT_W.
- One sub-module: duty_cycle_channel. It holds the per-channel CNT_W counter, with inputs clr, inc_en and sig, and output count.
  - It is instantiated CHANNELS times via generate.
  - The top level owns the FSM, the window counter, the output latch and the optional synchroniser.

Test Plan (CHANNELS=4, WINDOW=8 unless noted):
- Reset then single-shot: pulse start with enable=1 and sig_in=4'b0101 held constant. After 8 enabled cycles, valid pulses once with duty_out ch0=8, ch1=0, ch2=8, ch3=0; busy falls the same cycle valid rises.
- 50% duty on ch1 (toggling every cycle) with enable held high: ch1=4.
- Gated enable: enable toggles every cycle with sig_in[0]=1. valid arrives after 16 clocks and ch0=8. sig_in high only during enable=0 cycles gives ch0=0.
- Continuous mode: cont=1 for 3 windows with ch2 high on 3, 5 and 8 samples respectively. Three valid pulses spaced exactly 8 cycles apart report 3, 5 and 8. Dropping cont during window 3 ends in IDLE after that window.
- Boundary conditions: start while busy sets overrun, and the window length is unchanged. Asserting rst_n=0 at sample 5 gives all outputs 0, no valid, and state IDLE.
- WINDOW=255, CNT_W=8, all channels high: all channels report 255 with no wrap. With DUTY_CYCLE_SYNC_EN defined, the same stimulus delayed by 2 cycles gives identical counts.
